fft_reorder_16: RTL and testbench

Output reorder buffer that sits directly downstream of `fft_16point`. The radix-2² SDF pipeline emits each 16-point frame in bit-reversed bin order. This block captures each frame in one half of a ping-pong RAM and replays it in natural order (bin 0..15), with a valid/ready handshake on the output side. It sustains full throughput: one sample per cycle in, one sample per cycle out.

---
 rtl/fft_pkg.sv | 28 ++
 rtl/pingpong_ram.sv | 39 +++
 rtl/fft_reorder_16.sv | 120 ++++++++++++
 tb/tb_fft_reorder_16.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, sample type and bit-reversal helper for the FFT pipeline blocks.
package fft_pkg;

    localparam int FFT_N_LOG2 = 4;
    localparam int FFT_DW     = 16;

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;

    // Reverses the low 'width' bits of idx; bits above 'width' come back as zero.
    function automatic logic [FFT_N_LOG2-1:0] bitrev(input logic [FFT_N_LOG2-1:0] idx,
                                                     input int width);
        logic [FFT_N_LOG2-1:0] src;
        logic [FFT_N_LOG2-1:0] rev;
        src = idx;
        rev = '0;
        for (int i = 0; i < FFT_N_LOG2; i++) begin
            if (i < width) begin
                rev = {rev[FFT_N_LOG2-2:0], src[0]};
                src = src >> 1;
            end
        end
        return rev;
    endfunction

endpackage

// File: rtl/pingpong_ram.sv
// Two-bank simple dual-port RAM: one write port, one registered read port.
// The bank select is the address MSB; the read register doubles as the output stage.
module pingpong_ram
    import fft_pkg::*;
#(
    parameter int AW    = FFT_N_LOG2 + 1,
    parameter int WIDTH = 2 * FFT_DW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [2**AW];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read data holds its value while re_i is low, which gives backpressure stability.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_reorder_16.sv
// Ping-pong reorder buffer: captures bit-reversed FFT frames and replays them
// in natural bin order behind a valid/ready output handshake.
module fft_reorder_16
    import fft_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2,
    parameter int DW     = FFT_DW
) (
    input  logic          clk,
    input  logic          i_reset_n,
    input  logic          i_valid,
    input  logic [DW-1:0] i_re,
    input  logic [DW-1:0] i_im,
    output logic          o_ready,
    output logic          o_overflow,
    output logic          o_valid,
    output logic [DW-1:0] o_re,
    output logic [DW-1:0] o_im,
    output logic          o_last,
    input  logic          i_ready
);

    localparam logic [N_LOG2-1:0] CNT_LAST = '1;

    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [N_LOG2-1:0] wcnt_q, wcnt_d;
    logic [N_LOG2-1:0] rcnt_q, rcnt_d;
    logic [1:0]        full_q, full_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              ovf_q, ovf_d;
    logic              wr_en;
    logic              adv;
    logic [2*DW-1:0]   rd_data;

    assign o_ready = !full_q[wr_bank_q];
    assign wr_en   = i_valid && o_ready;
    assign adv     = full_q[rd_bank_q] && (!valid_q || i_ready);

    // A bank's flag is only ever set while it is the write bank and cleared while it
    // is the read bank; the write bank is never full, so the two cannot collide.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        full_d    = full_q;
        valid_d   = valid_q;
        last_d    = last_q;
        ovf_d     = ovf_q;

        if (wr_en) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == CNT_LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
        if (i_valid && !o_ready) begin
            ovf_d = 1'b1;
        end

        if (adv) begin
            valid_d = 1'b1;
            last_d  = (rcnt_q == CNT_LAST);
            rcnt_d  = rcnt_q + 1'b1;
            if (rcnt_q == CNT_LAST) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end else if (i_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            full_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            full_q    <= full_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
        end
    end

    pingpong_ram #(
        .AW    (N_LOG2 + 1),
        .WIDTH (2 * DW)
    ) u_ram (
        .clk_i   (clk),
        .rst_ni  (i_reset_n),
        .we_i    (wr_en),
        .waddr_i ({wr_bank_q, bitrev(wcnt_q, N_LOG2)}),
        .wdata_i ({i_re, i_im}),
        .re_i    (adv),
        .raddr_i ({rd_bank_q, rcnt_q}),
        .rdata_o (rd_data)
    );

    assign o_re       = rd_data[2*DW-1:DW];
    assign o_im       = rd_data[DW-1:0];
    assign o_valid    = valid_q;
    assign o_last     = last_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_fft_reorder_16.sv
// Self-checking bench for fft_reorder_16: a frame-level reference model predicts
// the natural-order output stream, bank availability and the overflow flag.
module tb_fft_reorder_16;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_re = '0;
    logic [DW-1:0] i_im = '0;
    logic          i_ready = 1'b0;
    logic          o_ready;
    logic          o_overflow;
    logic          o_valid;
    logic [DW-1:0] o_re;
    logic [DW-1:0] o_im;
    logic          o_last;

    fft_reorder_16 dut (
        .clk        (clk),
        .i_reset_n  (i_reset_n),
        .i_valid    (i_valid),
        .i_re       (i_re),
        .i_im       (i_im),
        .o_ready    (o_ready),
        .o_overflow (o_overflow),
        .o_valid    (o_valid),
        .o_re       (o_re),
        .o_im       (o_im),
        .o_last     (o_last),
        .i_ready    (i_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
    } smp_t;

    smp_t        expQ[$];
    logic [15:0] frameRe[16];
    logic [15:0] frameIm[16];
    int          fill = 0;
    int          fullFrames = 0;
    int          loaded = 0;
    bit          prevFree = 1'b1;
    bit          expOverflow = 1'b0;
    bit          held = 1'b0;
    logic [15:0] heldRe, heldIm;
    logic        heldLast;

    int errors = 0;
    int checks = 0;
    int edgeCount = 0;
    int firstOutEdge = -1;
    int run = 0;
    int maxRun = 0;
    int consumed = 0;
    int lastsSeen = 0;
    bit readyLowSeen = 1'b0;

    function automatic int rev4(input int v);
        int x;
        int r;
        x = v;
        r = 0;
        for (int k = 0; k < 4; k++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        expQ.delete();
        fill        = 0;
        fullFrames  = 0;
        loaded      = 0;
        prevFree    = 1'b1;
        held        = 1'b0;
        expOverflow = 1'b0;
    endtask

    // Evaluated just before an active edge, with this cycle's inputs already driven.
    task automatic checkOutput();
        smp_t e;
        bit   modelReady;
        int   j;
        if (held) begin
            check("hold_valid", o_valid, 1'b1);
            check("hold_re", o_re, heldRe);
            check("hold_im", o_im, heldIm);
            check("hold_last", o_last, heldLast);
        end
        // A bank is released when its final bin is loaded into the output stage.
        if (o_valid && prevFree) begin
            loaded++;
            if (loaded % 16 == 0) fullFrames--;
        end
        modelReady = (fullFrames < 2);
        if (!o_ready) readyLowSeen = 1'b1;
        if (i_valid) begin
            check("in_ready", o_ready, modelReady);
            if (modelReady) begin
                frameRe[fill] = i_re;
                frameIm[fill] = i_im;
                fill++;
                if (fill == 16) begin
                    for (int b = 0; b < 16; b++) begin
                        j = rev4(b);
                        e.re   = frameRe[j];
                        e.im   = frameIm[j];
                        e.last = (b == 15);
                        expQ.push_back(e);
                    end
                    fill = 0;
                    fullFrames++;
                end
            end else begin
                expOverflow = 1'b1;
            end
        end
        if (o_valid && i_ready) begin
            consumed++;
            if (o_last) lastsSeen++;
            if (expQ.size() == 0) begin
                check("out_unexpected", o_valid, 1'b0);
            end else begin
                e = expQ.pop_front();
                check("out_re", o_re, e.re);
                check("out_im", o_im, e.im);
                check("out_last", o_last, e.last);
            end
        end
        held     = o_valid && !i_ready;
        heldRe   = o_re;
        heldIm   = o_im;
        heldLast = o_last;
        prevFree = !o_valid || i_ready;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] re, input logic [15:0] im,
                                 input logic rdy);
        i_valid = v;
        i_re    = re;
        i_im    = im;
        i_ready = rdy;
        checkOutput();
        @(posedge clk);
        edgeCount++;
        #1;
        if (o_valid) begin
            run++;
            if (firstOutEdge < 0) firstOutEdge = edgeCount;
        end else begin
            run = 0;
        end
        if (run > maxRun) maxRun = run;
    endtask

    // mode 0: always ready, 1: alternate 1/0, 2: random ready
    task automatic drain(input int mode);
        logic rdy;
        for (int n = 0; n < 400 && (expQ.size() > 0 || o_valid); n++) begin
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (n % 2 == 0);
            else rdy = 1'($urandom);
            applyStimulus(1'b0, 16'h0, 16'h0, rdy);
        end
        check("drain_done", expQ.size(), 0);
        check("drain_idle", o_valid, 1'b0);
    endtask

    task automatic singleFrame();
        int startEdge;
        startEdge    = edgeCount;
        firstOutEdge = -1;
        consumed     = 0;
        lastsSeen    = 0;
        for (int j = 0; j < 16; j++) begin
            applyStimulus(1'b1, 16'(rev4(j)), 16'(16'h0100 + rev4(j)), 1'b1);
        end
        drain(0);
        check("latency", firstOutEdge - startEdge, 17);
        check("frame_count", consumed, 16);
        check("frame_lasts", lastsSeen, 1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #1;
        check("rst_valid", o_valid, 1'b0);
        check("rst_last", o_last, 1'b0);
        check("rst_re", o_re, 16'h0);
        check("rst_im", o_im, 16'h0);
        check("rst_ovf", o_overflow, 1'b0);
        check("rst_ready", o_ready, 1'b1);
        @(negedge clk);
        i_reset_n = 1'b1;
        @(posedge clk);
        edgeCount++;
        #1;

        singleFrame();

        // Three back-to-back random frames with the sink always ready.
        maxRun       = 0;
        readyLowSeen = 1'b0;
        lastsSeen    = 0;
        for (int j = 0; j < 48; j++) begin
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b1);
        end
        drain(0);
        check("gapless_run", maxRun, 48);
        check("ready_never_low", readyLowSeen, 1'b0);
        check("three_lasts", lastsSeen, 3);

        // Backpressure: alternating and then random i_ready during drains.
        for (int j = 0; j < 16; j++) begin
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b1);
        end
        drain(1);
        for (int j = 0; j < 16; j++) begin
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0);
        end
        drain(2);

        // Overflow: 40 samples with the sink stalled, only 32 fit.
        for (int j = 0; j < 40; j++) begin
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0);
        end
        check("ovf_set", o_overflow, 1'b1);
        check("ovf_model", o_overflow, expOverflow);
        check("ovf_ready_low", o_ready, 1'b0);
        consumed = 0;
        drain(0);
        check("ovf_drained", consumed, 32);
        check("ovf_sticky", o_overflow, 1'b1);

        // Reset while frame 1 drains and frame 2 is 7 samples in.
        for (int j = 0; j < 23; j++) begin
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b1);
        end
        check("pre_rst_valid", o_valid, 1'b1);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("async_rst_valid", o_valid, 1'b0);
        check("async_rst_last", o_last, 1'b0);
        check("async_rst_ovf", o_overflow, 1'b0);
        check("async_rst_ready", o_ready, 1'b1);
        resetModel();
        i_valid = 1'b0;
        @(negedge clk);
        i_reset_n = 1'b1;
        @(posedge clk);
        edgeCount++;
        #1;
        singleFrame();
        check("post_rst_ovf", o_overflow, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
